// File: rtl/open_scan_ctrl.sv
// ---------------------------------------------------------------------------
// open_scan_ctrl
//   Scan sequencer for a 4-digit multiplexed 7-segment display that shows the
//   letters O, P, E, N. It produces the letter select S for the downstream
//   letter decoder and a matching active-low one-hot digit enable DIG. It
//   supports start/stop control, an optional frame-count limit with a DONE
//   pulse, and blinking of the whole display.
//
// Ports
//   CLK     in   1            system clock, rising edge
//   RST     in   1            asynchronous reset, active-high
//   START   in   1            pulse: begin scanning (honoured in IDLE only)
//   STOP    in   1            pulse: abort scan, return to IDLE
//   BLINK   in   1            level: blank display on alternate blink phases
//   FRAMES  in   FRAME_WIDTH  frames to show before auto-stop; 0 = no limit
//   S       out  2            letter select (0=O, 1=P, 2=E, 3=N)
//   DIG     out  4            digit enables, active-low; DIG[3] = leftmost
//   BUSY    out  1            1 while scanning
//   DONE    out  1            one-cycle pulse when auto-stop completes
//
// All outputs are registered; their next values are built from the next
// state so that S and DIG always change together on the same edge.
// ---------------------------------------------------------------------------
module open_scan_ctrl #(
   parameter int DIV_WIDTH    = 16,
   parameter int DIV_MAX      = 49999,
   parameter int FRAME_WIDTH  = 8,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   input  logic                   STOP,
   input  logic                   BLINK,
   input  logic [FRAME_WIDTH-1:0] FRAMES,
   output logic [1:0]             S,
   output logic [3:0]             DIG,
   output logic                   BUSY,
   output logic                   DONE
);

   // Width of the frames-within-blink-half-period counter (at least 1 bit).
   localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [1:0]             s_q, s_d;
   logic [FRAME_WIDTH-1:0] frame_q, frame_d;
   logic [FRAME_WIDTH-1:0] limit_q, limit_d;
   logic [BF_W-1:0]        bf_q, bf_d;
   logic                   blink_q, blink_d;
   logic [3:0]             dig_q, dig_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                   tick_s;
   logic                   wrap_s;
   logic                   bf_last_s;
   logic                   auto_stop_s;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: slot tick, frame wrap, auto-stop detection.
   always_comb begin
      tick_s      = (state_q == ST_SCAN) && (div_q == DIV_WIDTH'(DIV_MAX));
      wrap_s      = tick_s && (s_q == 2'd3);
      bf_last_s   = (bf_q == BF_W'(BLINK_FRAMES - 1));
      // The wrap that completes frame number "limit" ends the run.
      auto_stop_s = wrap_s && (limit_q != {FRAME_WIDTH{1'b0}}) &&
                    ((frame_q + FRAME_WIDTH'(1)) == limit_q);
      state_d     = state_q;
      case (state_q)
         ST_IDLE: state_d = (START && !STOP) ? ST_SCAN : ST_IDLE;
         ST_SCAN: state_d = (STOP || auto_stop_s) ? ST_IDLE : ST_SCAN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and counter next values; IDLE values are the defaults.
   always_comb begin
      div_d   = {DIV_WIDTH{1'b0}};
      s_d     = 2'd0;
      frame_d = {FRAME_WIDTH{1'b0}};
      bf_d    = {BF_W{1'b0}};
      blink_d = 1'b0;
      limit_d = limit_q;
      dig_d   = 4'b1111;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      if (state_d == ST_SCAN) begin
         busy_d = 1'b1;
         if (state_q == ST_IDLE) begin
            // Entering SCAN: counters start from zero, limit is captured.
            limit_d = FRAMES;
         end else begin
            div_d   = tick_s ? {DIV_WIDTH{1'b0}} : (div_q + DIV_WIDTH'(1));
            s_d     = tick_s ? (s_q + 2'd1) : s_q;
            frame_d = wrap_s ? (frame_q + FRAME_WIDTH'(1)) : frame_q;
            bf_d    = wrap_s ? (bf_last_s ? {BF_W{1'b0}} : (bf_q + BF_W'(1))) : bf_q;
            blink_d = (wrap_s && bf_last_s) ? ~blink_q : blink_q;
         end
         // Select keeps advancing while blanked; only the enables are gated.
         dig_d = (BLINK && blink_d) ? 4'b1111 : ~(4'b1000 >> s_d);
      end else begin
         // A coincident STOP suppresses the completion pulse.
         done_d = auto_stop_s && !STOP;
      end
   end

   // Counter and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_q   <= {DIV_WIDTH{1'b0}};
         s_q     <= 2'd0;
         frame_q <= {FRAME_WIDTH{1'b0}};
         limit_q <= {FRAME_WIDTH{1'b0}};
         bf_q    <= {BF_W{1'b0}};
         blink_q <= 1'b0;
         dig_q   <= 4'b1111;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         s_q     <= s_d;
         frame_q <= frame_d;
         limit_q <= limit_d;
         bf_q    <= bf_d;
         blink_q <= blink_d;
         dig_q   <= dig_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign S    = s_q;
   assign DIG  = dig_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_open_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_open_scan_ctrl
//   Directed self-checking bench for open_scan_ctrl with DIV_MAX=3
//   (4 clocks per digit slot, 16 clocks per frame) and BLINK_FRAMES=2.
//   Inputs are driven 1 time unit after a rising edge and outputs are
//   sampled at that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_open_scan_ctrl;

   logic       CLK;
   logic       RST;
   logic       START;
   logic       STOP;
   logic       BLINK;
   logic [7:0] FRAMES;
   logic [1:0] S;
   logic [3:0] DIG;
   logic       BUSY;
   logic       DONE;

   int n_checks;
   int n_fail;

   open_scan_ctrl #(
      .DIV_WIDTH   (16),
      .DIV_MAX     (3),
      .FRAME_WIDTH (8),
      .BLINK_FRAMES(2)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .STOP  (STOP),
      .BLINK (BLINK),
      .FRAMES(FRAMES),
      .S     (S),
      .DIG   (DIG),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance n rising edges, landing 1 unit after the last one.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Pulse START for one edge; afterwards the first SCAN cycle is visible.
   task automatic pulse_start(input logic [7:0] frames);
      FRAMES = frames;
      START  = 1'b1;
      step(1);
      START  = 1'b0;
   endtask

   task automatic pulse_stop();
      STOP = 1'b1;
      step(1);
      STOP = 1'b0;
   endtask

   task automatic test_reset();
      logic [1:0] exp_s;
      // Power-on reset, checked before any clock edge.
      #3;
      n_checks++;
      if (DIG !== 4'b1111 || S !== 2'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_por: DIG=%b S=%0d BUSY=%b DONE=%b, want 1111 0 0 0", DIG, S, BUSY, DONE);
      end
      step(1);
      RST = 1'b0;
      step(2);
      // Reset in the middle of a scan, at S=1.
      pulse_start(8'd0);
      step(5);
      exp_s = 2'd1;
      n_checks++;
      if (S !== exp_s || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre: S=%0d BUSY=%b, want 1 1", S, BUSY);
      end
      RST = 1'b1;
      #2;
      n_checks++;
      if (DIG !== 4'b1111 || S !== 2'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: DIG=%b S=%0d BUSY=%b DONE=%b, want 1111 0 0 0", DIG, S, BUSY, DONE);
      end
      step(1);
      RST = 1'b0;
      step(3);
      n_checks++;
      if (DIG !== 4'b1111 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: DIG=%b BUSY=%b DONE=%b, want 1111 0 0", DIG, BUSY, DONE);
      end
   endtask

   task automatic test_basic_scan();
      logic [1:0] exp_s;
      logic [3:0] exp_dig;
      pulse_start(8'd0);
      for (int k = 0; k < 20; k++) begin
         exp_s   = 2'((k / 4) % 4);
         exp_dig = ~(4'b1000 >> exp_s);
         n_checks++;
         if (S !== exp_s || DIG !== exp_dig || BUSY !== 1'b1 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_scan k=%0d: S=%0d DIG=%b BUSY=%b DONE=%b, want S=%0d DIG=%b BUSY=1 DONE=0",
                     k, S, DIG, BUSY, DONE, exp_s, exp_dig);
         end
         step(1);
      end
      pulse_stop();
      n_checks++;
      if (BUSY !== 1'b0 || DIG !== 4'b1111 || S !== 2'd0) begin
         n_fail++;
         $display("FAIL basic_stop: BUSY=%b DIG=%b S=%0d, want 0 1111 0", BUSY, DIG, S);
      end
   endtask

   task automatic test_auto_stop();
      pulse_start(8'd2);
      for (int k = 0; k < 32; k++) begin
         if (k == 10) FRAMES = 8'd0;   // must not affect the captured limit
         n_checks++;
         if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_run k=%0d: BUSY=%b DONE=%b, want 1 0", k, BUSY, DONE);
         end
         step(1);
      end
      n_checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || DIG !== 4'b1111 || S !== 2'd0) begin
         n_fail++;
         $display("FAIL auto_done: DONE=%b BUSY=%b DIG=%b S=%0d, want 1 0 1111 0", DONE, BUSY, DIG, S);
      end
      step(1);
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || DIG !== 4'b1111) begin
         n_fail++;
         $display("FAIL auto_after: DONE=%b BUSY=%b DIG=%b, want 0 0 1111", DONE, BUSY, DIG);
      end
   endtask

   task automatic test_stop_mid_slot();
      pulse_start(8'd0);
      step(9);
      n_checks++;
      if (S !== 2'd2 || DIG !== 4'b1101) begin
         n_fail++;
         $display("FAIL stop_pre: S=%0d DIG=%b, want 2 1101", S, DIG);
      end
      pulse_stop();
      n_checks++;
      if (S !== 2'd0 || DIG !== 4'b1111 || DONE !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_edge: S=%0d DIG=%b DONE=%b BUSY=%b, want 0 1111 0 0", S, DIG, DONE, BUSY);
      end
      step(4);
      n_checks++;
      if (BUSY !== 1'b0 || DIG !== 4'b1111 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_idle: BUSY=%b DIG=%b DONE=%b, want 0 1111 0", BUSY, DIG, DONE);
      end
      pulse_start(8'd0);
      n_checks++;
      if (S !== 2'd0 || DIG !== 4'b0111 || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_restart: S=%0d DIG=%b BUSY=%b, want 0 0111 1", S, DIG, BUSY);
      end
      step(4);
      n_checks++;
      if (S !== 2'd1 || DIG !== 4'b1011) begin
         n_fail++;
         $display("FAIL stop_restart_slot1: S=%0d DIG=%b, want 1 1011", S, DIG);
      end
      pulse_stop();
   endtask

   task automatic test_blink();
      logic [1:0] exp_s;
      logic [3:0] exp_dig;
      BLINK = 1'b1;
      pulse_start(8'd0);
      for (int k = 0; k < 80; k++) begin
         exp_s   = 2'((k / 4) % 4);
         // Frames 2-3 (k 32..63) fall in the blanked half-period.
         exp_dig = (((k / 32) % 2) == 1) ? 4'b1111 : ~(4'b1000 >> exp_s);
         n_checks++;
         if (S !== exp_s || DIG !== exp_dig) begin
            n_fail++;
            $display("FAIL blink k=%0d: S=%0d DIG=%b, want S=%0d DIG=%b", k, S, DIG, exp_s, exp_dig);
         end
         step(1);
      end
      pulse_stop();
      BLINK = 1'b0;
   endtask

   task automatic test_corners();
      // START and STOP together in IDLE: stay IDLE.
      START = 1'b1;
      STOP  = 1'b1;
      step(1);
      START = 1'b0;
      STOP  = 1'b0;
      n_checks++;
      if (BUSY !== 1'b0 || DIG !== 4'b1111) begin
         n_fail++;
         $display("FAIL start_stop_idle: BUSY=%b DIG=%b, want 0 1111", BUSY, DIG);
      end
      // START during SCAN is ignored: the slot timing is not reset.
      pulse_start(8'd0);
      step(2);
      START = 1'b1;
      step(1);
      START = 1'b0;
      n_checks++;
      if (S !== 2'd0 || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL start_in_scan_k3: S=%0d BUSY=%b, want 0 1", S, BUSY);
      end
      step(1);
      n_checks++;
      if (S !== 2'd1 || DIG !== 4'b1011) begin
         n_fail++;
         $display("FAIL start_in_scan_k4: S=%0d DIG=%b, want 1 1011", S, DIG);
      end
      step(4);
      n_checks++;
      if (S !== 2'd2 || DIG !== 4'b1101) begin
         n_fail++;
         $display("FAIL start_in_scan_k8: S=%0d DIG=%b, want 2 1101", S, DIG);
      end
      pulse_stop();
   endtask

   task automatic test_back_to_back();
      // One-frame run, then a new START in the DONE cycle.
      pulse_start(8'd1);
      step(16);
      n_checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done: DONE=%b BUSY=%b, want 1 0", DONE, BUSY);
      end
      pulse_start(8'd0);
      n_checks++;
      if (BUSY !== 1'b1 || S !== 2'd0 || DIG !== 4'b0111 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_restart: BUSY=%b S=%0d DIG=%b DONE=%b, want 1 0 0111 0", BUSY, S, DIG, DONE);
      end
      // STOP on the tick that would complete a limited run: no DONE.
      pulse_stop();
      pulse_start(8'd1);
      step(15);
      pulse_stop();
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || DIG !== 4'b1111) begin
         n_fail++;
         $display("FAIL stop_beats_auto: DONE=%b BUSY=%b DIG=%b, want 0 0 1111", DONE, BUSY, DIG);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      RST      = 1'b1;
      START    = 1'b0;
      STOP     = 1'b0;
      BLINK    = 1'b0;
      FRAMES   = 8'd0;
      test_reset();
      test_basic_scan();
      test_auto_stop();
      test_stop_mid_slot();
      test_blink();
      test_corners();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
